// File: rtl/nco_pkg.sv
// nco_pkg: shared sweep-state encoding and default widths for the NCO phase generator (rev 1.0).
`default_nettype none

package nco_pkg;

    localparam int ACC_W_DEF   = 32;
    localparam int THETA_W_DEF = 10;
    localparam int STEP_W      = 24;

    typedef enum logic [1:0] {
        SW_HOLD = 2'd0,
        SW_UP   = 2'd1,
        SW_DOWN = 2'd2
    } sweep_state_t;

endpackage

`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: triangular sweep FSM owning the phase increment, with pending-word load override (rev 1.0).
`default_nettype none

module nco_sweep_ctrl
    import nco_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               sweep_en,
    input  logic [STEP_W-1:0]  sweep_step,
    input  logic [ACC_W-1:0]   freq_min,
    input  logic [ACC_W-1:0]   freq_max,
    input  logic               load,
    input  logic [ACC_W-1:0]   load_word,
    output logic [ACC_W-1:0]   inc,
    output sweep_state_t       state
);

    // One extra bit so a step past either bound is seen rather than wrapped.
    logic [ACC_W:0] step_ext;
    logic [ACC_W:0] sum_up;
    logic [ACC_W:0] diff_dn;
    logic           hit_max;
    logic           hit_min;

    assign step_ext = {{(ACC_W + 1 - STEP_W){1'b0}}, sweep_step};
    assign sum_up   = {1'b0, inc} + step_ext;
    assign diff_dn  = {1'b0, inc} - step_ext;
    assign hit_max  = (sum_up >= {1'b0, freq_max});
    assign hit_min  = diff_dn[ACC_W] || (diff_dn[ACC_W-1:0] <= freq_min);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc   <= '0;
            state <= SW_HOLD;
        end else if (clk_en) begin
            if (load) begin
                inc <= load_word;
            end else begin
                case (state)
                    SW_HOLD: begin
                        if (sweep_en) state <= SW_UP;
                    end
                    SW_UP: begin
                        if (!sweep_en) begin
                            state <= SW_HOLD;
                        end else if (hit_max) begin
                            inc   <= freq_max;
                            state <= SW_DOWN;
                        end else begin
                            inc <= sum_up[ACC_W-1:0];
                        end
                    end
                    SW_DOWN: begin
                        if (!sweep_en) begin
                            state <= SW_HOLD;
                        end else if (hit_min) begin
                            inc   <= freq_min;
                            state <= SW_UP;
                        end else begin
                            inc <= diff_dn[ACC_W-1:0];
                        end
                    end
                    default: state <= SW_HOLD;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nco_phase_gen.sv
// nco_phase_gen: phase-accumulator NCO with tuning-word handshake, sync-at-wrap loading and sweep (rev 1.0).
`default_nettype none

module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int THETA_W = THETA_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               ClkEn,
    input  logic [ACC_W-1:0]   FreqWord,
    input  logic               FreqValid,
    output logic               FreqReady,
    input  logic               SyncLoad,
    input  logic [THETA_W-1:0] PhaseOffset,
    input  logic               SweepEn,
    input  logic [STEP_W-1:0]  SweepStep,
    input  logic [ACC_W-1:0]   FreqMin,
    input  logic [ACC_W-1:0]   FreqMax,
    output logic [THETA_W-1:0] Theta,
    output logic               ThetaValid,
    output logic               Wrap
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] pending;
    logic             have_pending;
    logic             pending_sync;
    sweep_state_t     sweep_state;

    logic [ACC_W:0]   acc_sum;
    logic             carry;
    logic             handshake;
    logic             apply;
    logic             have_next;

    assign acc_sum   = {1'b0, acc} + {1'b0, inc};
    assign carry     = acc_sum[ACC_W];
    assign handshake = FreqValid && FreqReady;
    // A sync-mode word waits for the addition that carries out, so it lands on a phase wrap.
    assign apply     = ClkEn && have_pending && (!pending_sync || carry);
    assign have_next = handshake || (have_pending && !apply);

    nco_sweep_ctrl #(
        .ACC_W (ACC_W)
    ) u_sweep (
        .clk        (Clock),
        .rst_n      (Reset),
        .clk_en     (ClkEn),
        .sweep_en   (SweepEn),
        .sweep_step (SweepStep),
        .freq_min   (FreqMin),
        .freq_max   (FreqMax),
        .load       (apply),
        .load_word  (pending),
        .inc        (inc),
        .state      (sweep_state)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            acc          <= '0;
            pending      <= '0;
            have_pending <= 1'b0;
            pending_sync <= 1'b0;
            FreqReady    <= 1'b0;
            Theta        <= '0;
            ThetaValid   <= 1'b0;
            Wrap         <= 1'b0;
        end else begin
            if (ClkEn) acc <= acc_sum[ACC_W-1:0];
            if (handshake) begin
                pending      <= FreqWord;
                pending_sync <= SyncLoad;
            end
            have_pending <= have_next;
            FreqReady    <= !have_next;
            Theta        <= acc[ACC_W-1 -: THETA_W] + PhaseOffset;
            ThetaValid   <= ClkEn;
            Wrap         <= ClkEn && carry;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nco_phase_gen.sv
// tb_nco_phase_gen: randomized and directed scoreboard bench for nco_phase_gen against an integer reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_nco_phase_gen;
    import nco_pkg::*;

    localparam int     ACC_W   = 32;
    localparam int     THETA_W = 10;
    localparam longint MODV    = 64'h1_0000_0000;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               ClkEn;
    logic [ACC_W-1:0]   FreqWord;
    logic               FreqValid;
    logic               FreqReady;
    logic               SyncLoad;
    logic [THETA_W-1:0] PhaseOffset;
    logic               SweepEn;
    logic [23:0]        SweepStep;
    logic [ACC_W-1:0]   FreqMin;
    logic [ACC_W-1:0]   FreqMax;
    logic [THETA_W-1:0] Theta;
    logic               ThetaValid;
    logic               Wrap;

    always #5 Clock = ~Clock;

    nco_phase_gen #(.ACC_W(ACC_W), .THETA_W(THETA_W)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ClkEn       (ClkEn),
        .FreqWord    (FreqWord),
        .FreqValid   (FreqValid),
        .FreqReady   (FreqReady),
        .SyncLoad    (SyncLoad),
        .PhaseOffset (PhaseOffset),
        .SweepEn     (SweepEn),
        .SweepStep   (SweepStep),
        .FreqMin     (FreqMin),
        .FreqMax     (FreqMax),
        .Theta       (Theta),
        .ThetaValid  (ThetaValid),
        .Wrap        (Wrap)
    );

    typedef struct {
        longint       theta;
        bit           tv;
        bit           wrap;
        bit           ready;
        longint       inc;
        sweep_state_t st;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    // Reference model state, plain integers.
    longint       m_acc, m_inc, m_pend, m_theta;
    bit           m_have, m_sync, m_ready, m_tv, m_wrap;
    sweep_state_t m_st;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_inc = 0; m_pend = 0; m_theta = 0;
        m_have = 0; m_sync = 0; m_ready = 0; m_tv = 0; m_wrap = 0;
        m_st = SW_HOLD;
    endtask

    task automatic model_clock();
        longint sum, s2, d, nacc, ninc, step, fmin, fmax;
        bit     carry, apply, hs;
        sweep_state_t nst;
        step  = longint'(SweepStep);
        fmin  = longint'(FreqMin);
        fmax  = longint'(FreqMax);
        hs    = FreqValid && m_ready;
        carry = 0;
        nacc  = m_acc;
        ninc  = m_inc;
        nst   = m_st;
        m_theta = ((m_acc / (MODV / 1024)) + longint'(PhaseOffset)) % 1024;
        if (ClkEn) begin
            sum   = m_acc + m_inc;
            carry = (sum >= MODV);
            nacc  = sum % MODV;
            apply = m_have && (!m_sync || carry);
            if (apply) begin
                ninc   = m_pend;
                m_have = 0;
            end else if (m_st == SW_HOLD) begin
                if (SweepEn) nst = SW_UP;
            end else if (!SweepEn) begin
                nst = SW_HOLD;
            end else if (m_st == SW_UP) begin
                s2 = m_inc + step;
                if (s2 >= fmax) begin ninc = fmax; nst = SW_DOWN; end
                else ninc = s2;
            end else begin
                d = m_inc - step;
                if (d <= fmin) begin ninc = fmin; nst = SW_UP; end
                else ninc = d;
            end
        end
        if (hs) begin
            m_pend = longint'(FreqWord);
            m_sync = SyncLoad;
            m_have = 1;
        end
        m_ready = !m_have;
        m_tv    = ClkEn;
        m_wrap  = ClkEn && carry;
        m_acc   = nacc;
        m_inc   = ninc;
        m_st    = nst;
    endtask

    task automatic cycle();
        @(posedge Clock);
        model_clock();
        exp_q.push_back('{m_theta, m_tv, m_wrap, m_ready, m_inc, m_st});
        #2;
    endtask

    always @(negedge Clock) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("theta",      longint'(Theta),            e.theta);
                check("thetavalid", longint'(ThetaValid),       longint'(e.tv));
                check("wrap",       longint'(Wrap),             longint'(e.wrap));
                check("freqready",  longint'(FreqReady),        longint'(e.ready));
                check("inc",        longint'(dut.inc),          e.inc);
                check("state",      longint'(dut.sweep_state),  longint'(e.st));
            end
        end
    end

    task automatic do_reset();
        @(negedge Clock);
        #1;
        mon_en    = 1'b0;
        Reset     = 1'b0;
        ClkEn     = 1'b0;
        FreqValid = 1'b0;
        SweepEn   = 1'b0;
        #1;
        check("rst_theta",      longint'(Theta),           0);
        check("rst_thetavalid", longint'(ThetaValid),      0);
        check("rst_wrap",       longint'(Wrap),            0);
        check("rst_freqready",  longint'(FreqReady),       0);
        check("rst_inc",        longint'(dut.inc),         0);
        check("rst_acc",        longint'(dut.acc),         0);
        check("rst_state",      longint'(dut.sweep_state), longint'(SW_HOLD));
        exp_q.delete();
        model_reset();
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        cycle();
        mon_en = 1'b1;
        check("post_rst_ready", longint'(FreqReady),       1);
        check("post_rst_state", longint'(dut.sweep_state), longint'(SW_HOLD));
    endtask

    task automatic offer(input logic [ACC_W-1:0] w, input logic sync);
        FreqWord  = w;
        SyncLoad  = sync;
        FreqValid = 1'b1;
        cycle();
        FreqValid = 1'b0;
    endtask

    initial begin
        int wraps;
        Reset = 1'b0; ClkEn = 0; FreqWord = 0; FreqValid = 0; SyncLoad = 0;
        PhaseOffset = 0; SweepEn = 0; SweepStep = 0; FreqMin = 0; FreqMax = 0;
        model_reset();
        do_reset();

        // Basic tuning: one Theta step per cycle, wrap every 1024 cycles.
        ClkEn = 1'b1;
        offer(32'h0040_0000, 1'b0);
        repeat (4) cycle();
        wraps = 0;
        for (int i = 0; i < 2048; i++) begin
            cycle();
            if (Wrap) wraps++;
        end
        check("wrap_count_2048", longint'(wraps), 2);

        // Static phase offset.
        PhaseOffset = 10'h200;
        repeat (1100) cycle();

        // Sync load: word held until the wrapping addition.
        repeat (300) cycle();
        offer(32'h0080_0000, 1'b1);
        repeat (3) cycle();
        check("sync_ready_low", longint'(FreqReady), 0);
        repeat (1100) cycle();
        check("sync_applied_inc", longint'(dut.inc), 64'h0080_0000);

        // Gated enable with sweep running.
        FreqMin = 32'h0030_0000; FreqMax = 32'h0050_0000; SweepStep = 24'h01_0000;
        SweepEn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ClkEn = i[0];
            cycle();
        end
        ClkEn = 1'b1; SweepEn = 1'b0;
        repeat (3) cycle();

        // Directed triangular sweep from inc = 0x100.
        PhaseOffset = 0;
        offer(32'h0000_0100, 1'b0);
        repeat (3) cycle();
        FreqMin = 32'h100; FreqMax = 32'h1000; SweepStep = 24'h700;
        SweepEn = 1'b1;
        repeat (4) cycle();
        check("sweep_clamp_max", longint'(dut.inc), 64'h1000);
        check("sweep_state_dn",  longint'(dut.sweep_state), longint'(SW_DOWN));
        repeat (3) cycle();
        check("sweep_clamp_min", longint'(dut.inc), 64'h100);
        check("sweep_state_up",  longint'(dut.sweep_state), longint'(SW_UP));

        // Reset mid-sweep with a word pending.
        repeat (5) cycle();
        offer(32'h1234_5678, 1'b1);
        cycle();
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            ClkEn     = ($urandom_range(0, 3) != 0);
            FreqValid = ($urandom_range(0, 7) == 0);
            FreqWord  = $urandom();
            SyncLoad  = $urandom_range(0, 1);
            if ($urandom_range(0, 63) == 0) PhaseOffset = 10'($urandom());
            if ($urandom_range(0, 99) == 0) SweepEn = ~SweepEn;
            if ($urandom_range(0, 199) == 0) begin
                FreqMin   = 32'($urandom_range(0, 32'h0100_0000));
                FreqMax   = FreqMin + 32'($urandom_range(0, 32'h0100_0000));
                SweepStep = 24'($urandom());
            end
            cycle();
        end
        ClkEn = 0; FreqValid = 0;
        cycle();
        @(negedge Clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nco_phase_gen.md
NCO_PHASE_GEN -- requirements
Module: nco_phase_gen

Interface
REQ-001 SHALL take parameter ACC_W, default 32, phase accumulator width.
REQ-002 SHALL take parameter THETA_W, default 10, output phase width; it matches the sine table Theta input.
REQ-003 SHALL have port Clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ClkEn, input, 1, advance enable, shared with the downstream sine table.
REQ-006 SHALL have port FreqWord, input, ACC_W, new tuning word.
REQ-007 SHALL have port FreqValid, input, 1, FreqWord offered.
REQ-008 SHALL have port FreqReady, output, 1, tuning word can be accepted.
REQ-009 SHALL have port SyncLoad, input, 1, 1 = apply the new word at wrap, 0 = apply at the next ClkEn.
REQ-010 SHALL have port PhaseOffset, input, THETA_W, static phase offset added to Theta.
REQ-011 SHALL have port SweepEn, input, 1, enable triangular frequency sweep.
REQ-012 SHALL have port SweepStep, input, 24, unsigned increment delta per ClkEn.
REQ-013 SHALL have ports FreqMin and FreqMax, input, ACC_W each, sweep bounds; FreqMin <= FreqMax is required of the driver.
REQ-014 SHALL have port Theta, output, THETA_W, phase index to the sine table.
REQ-015 SHALL have port ThetaValid, output, 1, Theta is fresh this cycle.
REQ-016 SHALL have port Wrap, output, 1, one-cycle pulse on accumulator carry-out.

Function
REQ-017 SHALL add the active increment inc to acc modulo 2^ACC_W on each ClkEn=1 cycle, and hold acc when ClkEn=0.
REQ-018 SHALL register Theta as (acc[ACC_W-1 -: THETA_W] + PhaseOffset) mod 2^THETA_W, one cycle after acc updates.
REQ-019 SHALL register ThetaValid as the 1-cycle-delayed ClkEn, and register Wrap as the 1-cycle-delayed carry, qualified by ClkEn.
REQ-020 SHALL perform the handshake when FreqValid && FreqReady: the word is captured into a pending register and FreqReady drops the next cycle.
REQ-021 SHALL apply pending, when SyncLoad=0, to inc on the first subsequent ClkEn=1 cycle, with acc adding the old inc that cycle; FreqReady then rises the following cycle.
REQ-022 SHALL apply pending, when SyncLoad=1, in the ClkEn cycle whose addition produces carry-out; until then FreqReady stays low.
REQ-023 SHALL NOT reset acc on any tuning word change, so phase stays continuous.
REQ-024 SHALL implement a sweep FSM with states HOLD, UP and DOWN.
REQ-025 SHALL go from HOLD to UP on SweepEn=1, and from any state to HOLD on SweepEn=0; inc keeps its current value in HOLD.
REQ-026 SHALL, in UP on ClkEn, set inc = inc+SweepStep; if the result >= FreqMax, inc = FreqMax and the FSM goes to DOWN.
REQ-027 SHALL, in DOWN on ClkEn, set inc = inc-SweepStep; if the result <= FreqMin or underflows, inc = FreqMin and the FSM goes to UP.
REQ-028 SHALL compute sweep arithmetic at ACC_W+1 bits so overflow or underflow is detected, never wrapped.
REQ-029 SHALL let a pending-word apply override the sweep update in the same cycle, without changing the FSM state.
REQ-030 SHALL make no state change when ClkEn=0, except handshake capture.

Reset
REQ-031 SHALL, on Reset low, asynchronously clear acc, inc, pending, Theta, ThetaValid and Wrap to 0, set FreqReady=0 and set the FSM to HOLD.
REQ-032 SHALL set FreqReady=1 on the first clock after Reset deasserts.
REQ-033 SHALL discard any pending word on a reset mid-operation.

Structure
REQ-034 SHALL place the FSM state enumeration and the default ACC_W/THETA_W constants in the shared nco_pkg package.
REQ-035 SHALL use one sub-module, nco_sweep_ctrl, holding the FSM and the inc bound arithmetic; the accumulator, handshake and output registers stay in the top module.

Verification
REQ-036 SHALL check: FreqWord=0x0040_0000, SyncLoad=0, ClkEn=1 constant -> Theta steps +1 per cycle, with Wrap every 1024 cycles.
REQ-037 SHALL check: PhaseOffset=0x200 with the same word -> Theta equals the prior run plus 512 mod 1024.
REQ-038 SHALL check: SyncLoad=1, new word offered mid-period -> FreqReady stays low until the Wrap cycle, the new step applies after it, and acc is not reset.
REQ-039 SHALL check: ClkEn toggles every other cycle -> acc, Theta and sweep advance only on enabled cycles, and ThetaValid mirrors ClkEn delayed by 1.
REQ-040 SHALL check: FreqMin=0x100, FreqMax=0x1000, SweepStep=0x700, SweepEn=1 from inc=0x100 -> inc goes 0x800, 0xF00, 0x1000 (clamped) with state DOWN, then 0x900, 0x200, 0x100 (clamped) with state UP.
REQ-041 SHALL check: Reset asserted low mid-sweep with a word pending -> all outputs are 0 immediately without a clock edge, and after release FreqReady=1 and the state is HOLD.
